c3aibadapt_hip_sr_deser: RTL and testbench

Upstream feeder of the HIP async-update stage. Receives the serial HIP sideband shift-register stream (fast SR then slow SR, each followed by an even-parity bit) and deserializes it. Presents parallel FSR/SSR words with level load strobes that are held long enough for the downstream synchronizers to sample stable data. Also counts parity errors and flags overruns for DPRIO status.

---
 rtl/c3aibadapt_hip_sr_deser.sv | 185 ++++++++++++++++++
 tb/tb_c3aibadapt_hip_sr_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/c3aibadapt_hip_sr_deser.sv
// Deserializer for the HIP sideband shift-register stream: fast SR then slow SR,
// each followed by an even-parity bit; presents parallel words with held load strobes.
module c3aibadapt_hip_sr_deser #(
    parameter int                   FSR_WIDTH     = 4,
    parameter int                   SSR_WIDTH     = 40,
    parameter int                   LOAD_HOLD     = 4,
    parameter logic [FSR_WIDTH-1:0] FSR_RESET_VAL = '0,
    parameter logic [SSR_WIDTH-1:0] SSR_RESET_VAL = '1
) (
    input  logic                 sr_clock_rx_osc_clk,
    input  logic                 sr_reset_rx_osc_clk_rst_n,
    input  logic                 sr_bit_in,
    input  logic                 sr_bit_valid,
    input  logic                 sr_frame_start,
    input  logic                 r_sr_par_chk_en,
    input  logic                 sr_err_clr,
    output logic [FSR_WIDTH-1:0] hip_aib_async_fsr_in,
    output logic [SSR_WIDTH-1:0] hip_aib_async_ssr_in,
    output logic                 tx_async_fabric_hssi_fsr_load,
    output logic                 tx_async_fabric_hssi_ssr_load,
    output logic [7:0]           sr_par_err_cnt,
    output logic                 sr_overrun,
    output logic                 sr_busy
);

    localparam int MAXW_A = (FSR_WIDTH > SSR_WIDTH) ? FSR_WIDTH : SSR_WIDTH;
    localparam int MAXW   = (MAXW_A > LOAD_HOLD) ? MAXW_A : LOAD_HOLD;
    localparam int CW     = $clog2(MAXW + 1);

    localparam logic [CW-1:0] FSR_LAST = CW'(FSR_WIDTH - 1);
    localparam logic [CW-1:0] SSR_LAST = CW'(SSR_WIDTH - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(LOAD_HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FSR     = 3'd1,
        ST_FSR_PAR = 3'd2,
        ST_SSR     = 3'd3,
        ST_SSR_PAR = 3'd4,
        ST_SETUP   = 3'd5,
        ST_LOAD    = 3'd6
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [FSR_WIDTH-1:0] r_fsr_sh;
    logic [SSR_WIDTH-1:0] r_ssr_sh;
    logic [FSR_WIDTH-1:0] r_fsr_out;
    logic [SSR_WIDTH-1:0] r_ssr_out;
    logic                 r_fsr_ok;
    logic                 r_ssr_ok;
    logic                 r_fsr_load;
    logic                 r_ssr_load;
    logic [7:0]           r_err_cnt;
    logic                 r_overrun;

    logic                 w_start;
    logic                 w_in_frame;
    logic                 w_in_hold;
    logic                 w_fsr_par_ok;
    logic                 w_ssr_par_ok;
    logic                 w_err_inc;
    logic [FSR_WIDTH-1:0] w_fsr_next;
    logic [SSR_WIDTH-1:0] w_ssr_next;

    // sr_bit_valid qualifies both sr_bit_in and sr_frame_start; nothing is consumed without it.
    assign w_start    = sr_bit_valid & sr_frame_start;
    assign w_in_frame = (r_state == ST_FSR) || (r_state == ST_FSR_PAR) ||
                        (r_state == ST_SSR) || (r_state == ST_SSR_PAR);
    assign w_in_hold  = (r_state == ST_SETUP) || (r_state == ST_LOAD);

    assign w_fsr_par_ok = (sr_bit_in == ^r_fsr_sh) | ~r_sr_par_chk_en;
    assign w_ssr_par_ok = (sr_bit_in == ^r_ssr_sh) | ~r_sr_par_chk_en;

    // Right-shift with the new bit at the MSB: after WIDTH shifts the first bit sits at [0].
    assign w_fsr_next = (r_fsr_sh >> 1) | (FSR_WIDTH'(sr_bit_in) << (FSR_WIDTH - 1));
    assign w_ssr_next = (r_ssr_sh >> 1) | (SSR_WIDTH'(sr_bit_in) << (SSR_WIDTH - 1));

    always_comb begin
        w_err_inc = 1'b0;
        if (w_start && w_in_frame) begin
            w_err_inc = 1'b1;
        end else if (sr_bit_valid && (r_state == ST_FSR_PAR) && !w_fsr_par_ok) begin
            w_err_inc = 1'b1;
        end else if (sr_bit_valid && (r_state == ST_SSR_PAR) && !w_ssr_par_ok) begin
            w_err_inc = 1'b1;
        end
    end

    always_ff @(posedge sr_clock_rx_osc_clk or negedge sr_reset_rx_osc_clk_rst_n) begin
        if (!sr_reset_rx_osc_clk_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fsr_sh   <= '0;
            r_ssr_sh   <= '0;
            r_fsr_out  <= FSR_RESET_VAL;
            r_ssr_out  <= SSR_RESET_VAL;
            r_fsr_ok   <= 1'b0;
            r_ssr_ok   <= 1'b0;
            r_fsr_load <= 1'b0;
            r_ssr_load <= 1'b0;
        end else if (w_start && (w_in_frame || (r_state == ST_IDLE))) begin
            // A frame start outside SETUP/LOAD always (re)starts capture with this bit as FSR[0].
            r_fsr_sh <= w_fsr_next;
            r_cnt    <= CNT_ONE;
            r_state  <= (FSR_WIDTH == 1) ? ST_FSR_PAR : ST_FSR;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_FSR: begin
                    if (sr_bit_valid) begin
                        r_fsr_sh <= w_fsr_next;
                        if (r_cnt == FSR_LAST) r_state <= ST_FSR_PAR;
                        else                   r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_FSR_PAR: begin
                    if (sr_bit_valid) begin
                        r_fsr_ok <= w_fsr_par_ok;
                        r_cnt    <= '0;
                        r_state  <= ST_SSR;
                    end
                end
                ST_SSR: begin
                    if (sr_bit_valid) begin
                        r_ssr_sh <= w_ssr_next;
                        if (r_cnt == SSR_LAST) r_state <= ST_SSR_PAR;
                        else                   r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_SSR_PAR: begin
                    if (sr_bit_valid) begin
                        r_ssr_ok <= w_ssr_par_ok;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_fsr_ok) r_fsr_out <= r_fsr_sh;
                    if (r_ssr_ok) r_ssr_out <= r_ssr_sh;
                    r_cnt   <= '0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Data settled one edge earlier, so strobes rise only now and stay LOAD_HOLD cycles.
                    if (r_cnt == '0) begin
                        r_fsr_load <= r_fsr_ok;
                        r_ssr_load <= r_ssr_ok;
                        r_cnt      <= CNT_ONE;
                    end else if (r_cnt == HOLD_END) begin
                        r_fsr_load <= 1'b0;
                        r_ssr_load <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sr_clock_rx_osc_clk or negedge sr_reset_rx_osc_clk_rst_n) begin
        if (!sr_reset_rx_osc_clk_rst_n) begin
            r_err_cnt <= '0;
            r_overrun <= 1'b0;
        end else if (sr_err_clr) begin
            r_err_cnt <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_start && w_in_hold)              r_overrun <= 1'b1;
        end
    end

    assign hip_aib_async_fsr_in          = r_fsr_out;
    assign hip_aib_async_ssr_in          = r_ssr_out;
    assign tx_async_fabric_hssi_fsr_load = r_fsr_load;
    assign tx_async_fabric_hssi_ssr_load = r_ssr_load;
    assign sr_par_err_cnt                = r_err_cnt;
    assign sr_overrun                    = r_overrun;
    assign sr_busy                       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_c3aibadapt_hip_sr_deser.sv
// Directed bench for c3aibadapt_hip_sr_deser: frames, parity, stalls, abort,
// overrun, error clear, counter saturation and asynchronous reset.
module tb_c3aibadapt_hip_sr_deser;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        valid;
    logic        fs;
    logic        chk_en;
    logic        err_clr;
    logic [3:0]  fsr_out;
    logic [39:0] ssr_out;
    logic        fsr_load;
    logic        ssr_load;
    logic [7:0]  err_cnt;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    c3aibadapt_hip_sr_deser dut (
        .sr_clock_rx_osc_clk           (clk),
        .sr_reset_rx_osc_clk_rst_n     (rst_n),
        .sr_bit_in                     (bit_in),
        .sr_bit_valid                  (valid),
        .sr_frame_start                (fs),
        .r_sr_par_chk_en               (chk_en),
        .sr_err_clr                    (err_clr),
        .hip_aib_async_fsr_in          (fsr_out),
        .hip_aib_async_ssr_in          (ssr_out),
        .tx_async_fabric_hssi_fsr_load (fsr_load),
        .tx_async_fabric_hssi_ssr_load (ssr_load),
        .sr_par_err_cnt                (err_cnt),
        .sr_overrun                    (overrun),
        .sr_busy                       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid bit; with stall an invalid cycle follows carrying junk and a stray frame_start.
    task automatic send_bit(input logic b, input logic start, input logic stall);
        bit_in = b;
        valid  = 1'b1;
        fs     = start;
        step();
        valid  = 1'b0;
        fs     = 1'b0;
        if (stall) begin
            bit_in = 1'($urandom_range(0, 1));
            fs     = 1'b1;
            step();
            fs     = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [3:0] f, input logic flip, input logic [39:0] s,
                              input logic stall);
        for (int i = 0; i < 4; i++) send_bit(f[i], i == 0, stall);
        send_bit((^f) ^ flip, 1'b0, stall);
        for (int i = 0; i < 40; i++) send_bit(s[i], 1'b0, stall);
        send_bit(^s, 1'b0, 1'b0);
    endtask

    // Entered one cycle after the SSR parity edge; follows data update and load window.
    task automatic check_window(input string tag, input logic [3:0] ef, input logic [39:0] es,
                                input logic efl, input logic esl, input logic inject);
        int nf;
        int ns;
        nf = 0;
        ns = 0;
        check({tag, "_busy_setup"}, 64'(busy), 64'd1);
        step();
        check({tag, "_fsr_data"}, 64'(fsr_out), 64'(ef));
        check({tag, "_ssr_data"}, 64'(ssr_out), 64'(es));
        check({tag, "_loads_early"}, 64'({fsr_load, ssr_load}), 64'd0);
        for (int i = 0; i < 6; i++) begin
            if (inject && i == 1) begin
                valid  = 1'b1;
                fs     = 1'b1;
                bit_in = 1'b1;
            end
            step();
            valid = 1'b0;
            fs    = 1'b0;
            if (i == 0) check({tag, "_loads_rise"}, 64'({fsr_load, ssr_load}), 64'({efl, esl}));
            nf += int'(fsr_load);
            ns += int'(ssr_load);
        end
        check({tag, "_fsr_load_cycles"}, 64'(nf), efl ? 64'd4 : 64'd0);
        check({tag, "_ssr_load_cycles"}, 64'(ns), esl ? 64'd4 : 64'd0);
        check({tag, "_fsr_stable"}, 64'(fsr_out), 64'(ef));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        bit_in  = 1'b0;
        valid   = 1'b0;
        fs      = 1'b0;
        chk_en  = 1'b1;
        err_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        check("rst_fsr", 64'(fsr_out), 64'h0);
        check("rst_ssr", 64'(ssr_out), 64'hFF_FFFF_FFFF);
        check("rst_loads", 64'({fsr_load, ssr_load}), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Stray valid bits without frame_start are dropped.
        send_bit(1'b1, 1'b0, 1'b0);
        check("idle_drop_busy", 64'(busy), 64'd0);

        send_frame(4'hA, 1'b0, 40'h12_3456_789A, 1'b0);
        check("good_pre_update", 64'(fsr_out), 64'h0);
        check_window("good", 4'hA, 40'h12_3456_789A, 1'b1, 1'b1, 1'b0);
        check("good_err", 64'(err_cnt), 64'd0);

        send_frame(4'h5, 1'b1, 40'hA5_5A0F_F0C3, 1'b0);
        check_window("fpar_bad", 4'hA, 40'hA5_5A0F_F0C3, 1'b0, 1'b1, 1'b0);
        check("fpar_bad_err", 64'(err_cnt), 64'd1);

        chk_en = 1'b0;
        send_frame(4'h3, 1'b1, 40'h00_0000_0001, 1'b0);
        check_window("par_off", 4'h3, 40'h00_0000_0001, 1'b1, 1'b1, 1'b0);
        check("par_off_err", 64'(err_cnt), 64'd1);
        chk_en = 1'b1;

        send_frame(4'hC, 1'b0, 40'hFE_DCBA_9876, 1'b1);
        check_window("stall", 4'hC, 40'hFE_DCBA_9876, 1'b1, 1'b1, 1'b0);
        check("stall_err", 64'(err_cnt), 64'd1);

        // Abandon a frame after 20 SSR bits; the next frame_start restarts capture.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'(i % 3 == 0), 1'b0, 1'b0);
        send_frame(4'hE, 1'b0, 40'h0F_1E2D_3C4B, 1'b0);
        check_window("abort", 4'hE, 40'h0F_1E2D_3C4B, 1'b1, 1'b1, 1'b0);
        check("abort_err", 64'(err_cnt), 64'd2);

        send_frame(4'h1, 1'b0, 40'h80_0000_0000, 1'b0);
        check_window("overrun", 4'h1, 40'h80_0000_0000, 1'b1, 1'b1, 1'b1);
        check("overrun_flag", 64'(overrun), 64'd1);
        check("overrun_err", 64'(err_cnt), 64'd2);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", 64'(err_cnt), 64'd0);
        check("clr_overrun", 64'(overrun), 64'd0);

        for (int n = 0; n < 260; n++) begin
            send_frame(4'h6, 1'b1, 40'h00_0000_0000, 1'b0);
            repeat (7) step();
        end
        check("sat_err", 64'(err_cnt), 64'd255);
        check("sat_fsr_kept", 64'(fsr_out), 64'h1);

        send_frame(4'h9, 1'b0, 40'h55_AA55_AA55, 1'b0);
        step();
        step();
        check("rstload_load_high", 64'({fsr_load, ssr_load}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstload_loads", 64'({fsr_load, ssr_load}), 64'd0);
        check("rstload_fsr", 64'(fsr_out), 64'h0);
        check("rstload_ssr", 64'(ssr_out), 64'hFF_FFFF_FFFF);
        check("rstload_err", 64'(err_cnt), 64'd0);
        check("rstload_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
